capture_window_ctrl: RTL and testbench

Controller that shares one external capture register (DW-bit D flop with setup/hold timing checks) among N_REQ requesters. Each accepted word is driven onto the flop's D input a programmed number of cycles before the capture strobe and held a programmed number of cycles after it. The captured Q is then read back and compared. Sits between requester logic and the capture flop in the gate-level timing test setup, so SDF-annotated runs never see D move inside the setup/hold window.

---
 rtl/capture_window_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/capture_window_ctrl.sv | 163 ++++++++++++++++
 tb/tb_capture_window_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_window_pkg.sv
// Shared types and sizing helpers for the capture window controller.
package capture_window_pkg;

  // Width of the saturating mismatch counter.
  localparam int ERR_CNT_W = 16;

  // Default window lengths and the counter width they imply.
  localparam int SETUP_CYC_DEF = 2;
  localparam int HOLD_CYC_DEF  = 1;

  // Controller phases: drive D early, strobe, keep D, then compare Q.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    CHECK   = 3'd4
  } state_t;

  // Counter width able to hold the longer of the two window lengths.
  function automatic int cnt_width(input int setup_cyc, input int hold_cyc);
    int w_max;
    w_max = (setup_cyc > hold_cyc) ? setup_cyc : hold_cyc;
    return $clog2(w_max + 1);
  endfunction

  localparam int CNT_W = cnt_width(SETUP_CYC_DEF, HOLD_CYC_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after i_ptr.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  input  logic             i_enable,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx
);

  logic          w_found;
  logic [IW-1:0] w_sel;

  // Scan requesters starting at the pointer and wrapping; first hit wins.
  always_comb begin
    o_grant = {N_REQ{1'b0}};
    o_idx   = {IW{1'b0}};
    w_found = 1'b0;
    w_sel   = {IW{1'b0}};
    for (int off = 0; off < N_REQ; off++) begin
      w_sel = IW'((int'(i_ptr) + off) % N_REQ);
      if (i_enable && !w_found && i_req[w_sel]) begin
        o_grant[w_sel] = 1'b1;
        o_idx          = w_sel;
        w_found        = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/capture_window_ctrl.sv
// Shares one external capture flop among N_REQ requesters, keeping D
// stable SETUP_CYC cycles before and HOLD_CYC cycles after the strobe,
// then compares the captured Q with the word that was sent.
module capture_window_ctrl
  import capture_window_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int DW        = 8,
  parameter  int SETUP_CYC = 2,
  parameter  int HOLD_CYC  = 1,
  localparam int IW        = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*DW-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [DW-1:0]        cap_d,
  output logic                 cap_en,
  input  logic [DW-1:0]        cap_q,
  output logic                 rsp_valid,
  output logic [IW-1:0]        rsp_id,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int LCNT_W = cnt_width(SETUP_CYC, HOLD_CYC);

  // A zero-length window would let D move at the capture edge.
  if (SETUP_CYC < 1 || HOLD_CYC < 1 || N_REQ < 2) begin : g_param_check
    $error("capture_window_ctrl: need SETUP_CYC>=1, HOLD_CYC>=1, N_REQ>=2");
  end

  state_t                 r_state;
  state_t                 w_next_state;
  logic [LCNT_W-1:0]      r_cnt;
  logic [LCNT_W-1:0]      w_cnt_nxt;
  logic [IW-1:0]          r_ptr;
  logic [IW-1:0]          r_id;
  logic [DW-1:0]          r_data;
  logic [DW-1:0]          r_cap_d;
  logic                   r_cap_en;
  logic                   r_rsp_valid;
  logic [IW-1:0]          r_rsp_id;
  logic                   r_rsp_err;
  logic [ERR_CNT_W-1:0]   r_err_cnt;
  logic [N_REQ-1:0]       w_grant;
  logic [IW-1:0]          w_win_idx;
  logic [DW-1:0]          w_win_data;
  logic                   w_accept;
  logic                   w_mismatch;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req    (req_valid),
    .i_ptr    (r_ptr),
    .i_enable (r_state == IDLE),
    .o_grant  (w_grant),
    .o_idx    (w_win_idx)
  );

  assign w_accept   = |w_grant;
  assign w_win_data = req_data[w_win_idx*DW +: DW];
  assign w_mismatch = (cap_q != r_data);

  assign req_ready = w_grant;
  assign cap_d     = r_cap_d;
  assign cap_en    = r_cap_en;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;
  assign err_cnt   = r_err_cnt;

  // Next-state and window counter logic.
  always_comb begin
    w_next_state = r_state;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = SETUP;
          w_cnt_nxt    = LCNT_W'(SETUP_CYC - 1);
        end else begin
          w_next_state = IDLE;
        end
      end
      SETUP: begin
        if (r_cnt == {LCNT_W{1'b0}}) begin
          w_next_state = CAPTURE;
        end else begin
          w_cnt_nxt = r_cnt - LCNT_W'(1);
        end
      end
      CAPTURE: begin
        w_next_state = HOLD;
        w_cnt_nxt    = LCNT_W'(HOLD_CYC - 1);
      end
      HOLD: begin
        if (r_cnt == {LCNT_W{1'b0}}) begin
          w_next_state = CHECK;
        end else begin
          w_cnt_nxt = r_cnt - LCNT_W'(1);
        end
      end
      CHECK: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
        w_cnt_nxt    = {LCNT_W{1'b0}};
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= {LCNT_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Latch the accepted word, drive it onto D and advance the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= {DW{1'b0}};
      r_id    <= {IW{1'b0}};
      r_cap_d <= {DW{1'b0}};
      r_ptr   <= {IW{1'b0}};
    end else if (w_accept) begin
      r_data  <= w_win_data;
      r_id    <= w_win_idx;
      r_cap_d <= w_win_data;
      r_ptr   <= (w_win_idx == IW'(N_REQ - 1)) ? {IW{1'b0}} : w_win_idx + IW'(1);
    end
  end

  // Strobe, response and mismatch counter, all registered off next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_en    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= {IW{1'b0}};
      r_rsp_err   <= 1'b0;
      r_err_cnt   <= {ERR_CNT_W{1'b0}};
    end else begin
      r_cap_en    <= (w_next_state == CAPTURE);
      r_rsp_valid <= (w_next_state == CHECK);
      if (w_next_state == CHECK) begin
        r_rsp_id  <= r_id;
        r_rsp_err <= w_mismatch;
        if (w_mismatch && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
      end else begin
        r_rsp_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_capture_window_ctrl.sv
// Self-checking bench for capture_window_ctrl: table-driven transactions on
// a default-parameter instance plus reset, saturation and a random stream
// on a SETUP_CYC=1/HOLD_CYC=1 instance with a setup/hold-checking flop model.
module tb_capture_window_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: defaults (SETUP_CYC=2, HOLD_CYC=1).
  logic [3:0]  a_valid, a_ready;
  logic [31:0] a_data;
  logic [7:0]  a_cap_d;
  logic [7:0]  a_cap_q = 8'h00;
  logic        a_cap_en, a_rsp_valid, a_rsp_err, a_bad;
  logic [1:0]  a_rsp_id;
  logic [15:0] a_err_cnt;

  capture_window_ctrl #(.N_REQ(4), .DW(8), .SETUP_CYC(2), .HOLD_CYC(1)) dut (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_data(a_data),
    .req_ready(a_ready), .cap_d(a_cap_d), .cap_en(a_cap_en), .cap_q(a_cap_q),
    .rsp_valid(a_rsp_valid), .rsp_id(a_rsp_id), .rsp_err(a_rsp_err),
    .err_cnt(a_err_cnt)
  );

  // Flop model A; a_bad makes it capture 8'h00 instead of D.
  always @(posedge clk) if (a_cap_en) a_cap_q <= a_bad ? 8'h00 : a_cap_d;

  // Instance B: minimal window for the random stream.
  logic [3:0]  b_valid, b_ready;
  logic [31:0] b_data;
  logic [7:0]  b_cap_d;
  logic [7:0]  b_cap_q = 8'h00;
  logic        b_cap_en, b_rsp_valid, b_rsp_err;
  logic [1:0]  b_rsp_id;
  logic [15:0] b_err_cnt;

  capture_window_ctrl #(.N_REQ(4), .DW(8), .SETUP_CYC(1), .HOLD_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data),
    .req_ready(b_ready), .cap_d(b_cap_d), .cap_en(b_cap_en), .cap_q(b_cap_q),
    .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_err(b_rsp_err),
    .err_cnt(b_err_cnt)
  );

  // Flop model B plus setup/hold monitor: D must match in the cycle before,
  // during and after every strobe cycle.
  always @(posedge clk) if (b_cap_en) b_cap_q <= b_cap_d;

  logic [7:0] bd0 = 8'h00, bd1 = 8'h00;
  logic       ben0 = 1'b0;
  int         viol = 0;
  always @(negedge clk) begin
    if (ben0 && !((bd1 == bd0) && (bd0 == b_cap_d))) viol <= viol + 1;
    bd1  <= bd0;
    bd0  <= b_cap_d;
    ben0 <= b_cap_en;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One transaction on A: drive at an IDLE negedge, check grant, then
  // check every cycle up to and including CHECK (accept t, strobe t+3, rsp t+5).
  task automatic run_txn(input int tag, input logic [3:0] v, input logic [31:0] data,
                         input logic bad, input logic [1:0] id, input logic [7:0] d,
                         input logic err);
    @(negedge clk);
    a_valid = v;
    a_data  = data;
    a_bad   = bad;
    #1;
    chk($sformatf("t%0d grant", tag), 32'(a_ready), 32'(4'b0001 << id));
    if (err) exp_cnt = (exp_cnt == 16'hFFFF) ? 16'hFFFF : exp_cnt + 16'd1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("t%0d k%0d cap_d", tag, k), 32'(a_cap_d), 32'(d));
      chk($sformatf("t%0d k%0d cap_en", tag, k), 32'(a_cap_en), 32'(k == 3));
      chk($sformatf("t%0d k%0d rsp_valid", tag, k), 32'(a_rsp_valid), 32'(k == 5));
      chk($sformatf("t%0d k%0d ready_busy", tag, k), 32'(a_ready), 32'd0);
      if (k == 5) begin
        chk($sformatf("t%0d rsp_id", tag), 32'(a_rsp_id), 32'(id));
        chk($sformatf("t%0d rsp_err", tag), 32'(a_rsp_err), 32'(err));
        chk($sformatf("t%0d err_cnt", tag), 32'(a_err_cnt), 32'(exp_cnt));
      end
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        bad;
    logic [1:0]  id;
    logic [7:0]  d;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  // Watchdog so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ptr walks 0 ->3 ->0.. ; rows 2..6 show continuous service 0,1,2,3,0.
    vecs[0] = '{4'b0100, 32'h00A5_0000, 1'b0, 2'd2, 8'hA5, 1'b0};
    vecs[1] = '{4'b1000, 32'hD4C3_B2A1, 1'b0, 2'd3, 8'hD4, 1'b0};
    vecs[2] = '{4'b1111, 32'h4433_2211, 1'b0, 2'd0, 8'h11, 1'b0};
    vecs[3] = '{4'b1111, 32'h4433_2211, 1'b0, 2'd1, 8'h22, 1'b0};
    vecs[4] = '{4'b1111, 32'h4433_2211, 1'b0, 2'd2, 8'h33, 1'b0};
    vecs[5] = '{4'b1111, 32'h4433_2211, 1'b0, 2'd3, 8'h44, 1'b0};
    vecs[6] = '{4'b1111, 32'h4433_2211, 1'b0, 2'd0, 8'h11, 1'b0};
    vecs[7] = '{4'b0010, 32'h5566_3C77, 1'b1, 2'd1, 8'h3C, 1'b1};
    vecs[8] = '{4'b0011, 32'h0000_BB99, 1'b0, 2'd0, 8'h99, 1'b0};
    vecs[9] = '{4'b0011, 32'h0000_BB99, 1'b0, 2'd1, 8'hBB, 1'b0};

    rst = 1'b1;
    a_valid = 4'b0000; a_data = 32'h0; a_bad = 1'b0;
    b_valid = 4'b0000; b_data = 32'h0;
    exp_cnt = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    chk("reset ready", 32'(a_ready), 32'd0);
    chk("reset cap_d", 32'(a_cap_d), 32'd0);
    chk("reset cap_en", 32'(a_cap_en), 32'd0);
    chk("reset rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("reset rsp_id", 32'(a_rsp_id), 32'd0);
    chk("reset rsp_err", 32'(a_rsp_err), 32'd0);
    chk("reset err_cnt", 32'(a_err_cnt), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_txn(i, vecs[i].valid, vecs[i].data, vecs[i].bad, vecs[i].id, vecs[i].d, vecs[i].err);
    end

    // Idle: cap_d keeps the last word, nothing strobes or responds.
    @(negedge clk);
    a_valid = 4'b0000;
    a_bad   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle cap_d", 32'(a_cap_d), 32'hBB);
      chk("idle cap_en", 32'(a_cap_en), 32'd0);
      chk("idle rsp_valid", 32'(a_rsp_valid), 32'd0);
      chk("idle ready", 32'(a_ready), 32'd0);
    end

    // Reset pulsed during HOLD (cycle t+4): no response, all outputs reset.
    @(negedge clk);
    a_valid = 4'b0001;
    a_data  = 32'h0000_005A;
    #1;
    chk("rstmid grant", 32'(a_ready), 32'h1);
    repeat (4) @(negedge clk);
    chk("rstmid hold cap_d", 32'(a_cap_d), 32'h5A);
    rst     = 1'b1;
    a_valid = 4'b0000;
    @(negedge clk);
    chk("rstmid rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rstmid cap_d", 32'(a_cap_d), 32'd0);
    chk("rstmid cap_en", 32'(a_cap_en), 32'd0);
    chk("rstmid rsp_id", 32'(a_rsp_id), 32'd0);
    chk("rstmid rsp_err", 32'(a_rsp_err), 32'd0);
    chk("rstmid err_cnt", 32'(a_err_cnt), 32'd0);
    chk("rstmid ready", 32'(a_ready), 32'd0);
    rst     = 1'b0;
    exp_cnt = 16'h0000;
    @(negedge clk);
    chk("rstmid no late rsp", 32'(a_rsp_valid), 32'd0);

    // Pointer back at 0: requester 0 wins over 1, then 1 is served.
    run_txn(20, 4'b0011, 32'h0000_2211, 1'b0, 2'd0, 8'h11, 1'b0);
    run_txn(21, 4'b0011, 32'h0000_2211, 1'b0, 2'd1, 8'h22, 1'b0);

    // Saturation: preload the counter near the top, then keep failing.
    @(negedge clk);
    a_valid = 4'b0000;
    force dut.r_err_cnt = 16'hFFFD;
    #1;
    release dut.r_err_cnt;
    exp_cnt = 16'hFFFD;
    run_txn(30, 4'b0100, 32'h00F0_0000, 1'b1, 2'd2, 8'hF0, 1'b1);
    run_txn(31, 4'b0100, 32'h00F0_0000, 1'b1, 2'd2, 8'hF0, 1'b1);
    run_txn(32, 4'b0100, 32'h00F0_0000, 1'b1, 2'd2, 8'hF0, 1'b1);
    @(negedge clk);
    a_valid = 4'b0000;
    a_bad   = 1'b0;

    // Random stream on instance B with the minimal window.
    for (int w = 0; w < 200; w++) begin
      int          r;
      int          waited;
      logic [31:0] dat;
      logic [7:0]  lane;
      r    = int'($urandom_range(3, 0));
      dat  = $urandom;
      lane = dat[r*8 +: 8];
      @(negedge clk);
      b_valid = 4'b0001 << r;
      b_data  = dat;
      #1;
      waited = 0;
      while ((b_ready == 4'b0000) && (waited < 8)) begin
        @(negedge clk);
        #1;
        waited++;
      end
      chk($sformatf("b%0d grant", w), 32'(b_ready), 32'(4'b0001 << r));
      @(negedge clk);
      b_valid = 4'b0000;
      waited = 0;
      while (!b_rsp_valid && (waited < 10)) begin
        @(negedge clk);
        waited++;
      end
      chk($sformatf("b%0d rsp_valid", w), 32'(b_rsp_valid), 32'd1);
      chk($sformatf("b%0d rsp_id", w), 32'(b_rsp_id), 32'(r));
      chk($sformatf("b%0d rsp_err", w), 32'(b_rsp_err), 32'd0);
      chk($sformatf("b%0d cap_d", w), 32'(b_cap_d), 32'(lane));
    end
    @(negedge clk);
    chk("b setup_hold_violations", 32'(viol), 32'd0);
    chk("b err_cnt", 32'(b_err_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
